// File: rtl/word_byte_sched_pkg.sv
// Shared definitions for the word-to-byte scheduler.
//   WORD_BYTES / SCHED_NREQ : default bytes per word and requester count
//   state_t                 : scheduler states
//   word_byte()             : byte slice of a packed word (words up to MAX_BYTES bytes)
package word_byte_sched_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned SCHED_NREQ = 4;
   localparam int unsigned MAX_BYTES  = 32;

   typedef enum logic {IDLE, SEND} state_t;

   // Byte idx of a word, LSB byte is index 0. Narrower words are zero-extended by the caller.
   function automatic logic [7:0] word_byte(input logic [8*MAX_BYTES-1:0] word,
                                            input int unsigned idx);
      return word[8*idx +: 8];
   endfunction

endpackage

// File: rtl/word_byte_sched_rr_arbiter.sv
// Combinational round-robin priority search.
//   req         : request vector
//   ptr         : index of the last granted requester; search starts at ptr+1
//   grant_valid : at least one request is pending
//   grant_idx   : first requester found searching ptr+1, ptr+2, ... mod NREQ
module word_byte_sched_rr_arbiter
   import word_byte_sched_pkg::*;
#(
   parameter int unsigned  NREQ = SCHED_NREQ,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            grant_valid,
   output logic [IDW-1:0]  grant_idx
);

   always_comb begin
      int unsigned cand;
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      // k runs to NREQ so the last candidate is ptr itself
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = (32'(ptr) + k) % NREQ;
         if (!grant_valid && req[IDW'(cand)]) begin
            grant_valid = 1'b1;
            grant_idx   = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/word_byte_sched.sv
// Round-robin scheduler sharing one word-to-byte serializer between NREQ producers.
//   CLK_0, RST  : clock (rising edge), asynchronous active-high reset
//   req/data_in : per-requester word-valid level and packed words
//   ack         : one-hot, one-cycle pulse when a word is captured
//   byte_*      : valid/ready byte stream, LSB byte first, with first/last tags
//   src_id      : requester owning the current word
//   busy        : high while a word is being sent
module word_byte_sched
   import word_byte_sched_pkg::*;
#(
   parameter int unsigned  NREQ  = SCHED_NREQ,
   parameter int unsigned  BYTES = WORD_BYTES,
   localparam int unsigned IDW   = $clog2(NREQ)
) (
   input  logic                    CLK_0,
   input  logic                    RST,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*8*BYTES-1:0] data_in,
   output logic [NREQ-1:0]         ack,
   output logic [7:0]              byte_out,
   output logic                    byte_valid,
   input  logic                    byte_ready,
   output logic                    byte_first,
   output logic                    byte_last,
   output logic [IDW-1:0]          src_id,
   output logic                    busy
);

   localparam int unsigned   WW       = 8 * BYTES;
   localparam int unsigned   IW       = $clog2(BYTES) + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [WW-1:0]          word_q, word_d;
   logic [IDW-1:0]         ptr_q, ptr_d;
   logic [IDW-1:0]         src_q, src_d;
   logic [NREQ-1:0]        ack_q, ack_d;
   logic                   grant_valid;
   logic [IDW-1:0]         grant_idx;
   logic [8*MAX_BYTES-1:0] word_ext;

   word_byte_sched_rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req         (req),
      .ptr         (ptr_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // ptr resets to NREQ-1 so requester 0 wins the first search
   always_ff @(posedge CLK_0 or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         word_q  <= '0;
         ptr_q   <= IDW'(NREQ - 1);
         src_q   <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         ptr_q   <= ptr_d;
         src_q   <= src_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      ptr_d   = ptr_q;
      src_d   = src_q;
      ack_d   = '0;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               word_d           = data_in[32'(grant_idx)*WW +: WW];
               ptr_d            = grant_idx;
               src_d            = grant_idx;
               idx_d            = '0;
               ack_d[grant_idx] = 1'b1;
               state_d          = SEND;
            end
         end
         SEND: begin
            // byte_valid is always high here, so ready alone means transfer
            if (byte_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Indexing the captured word is equivalent to shifting it right per byte; idx stays on
   // the last byte in IDLE so byte_out holds its final value between words.
   always_comb begin
      word_ext           = '0;
      word_ext[WW-1:0]   = word_q;
      byte_out           = word_byte(word_ext, 32'(idx_q));
      byte_valid         = (state_q == SEND);
      busy               = (state_q == SEND);
      byte_first         = (state_q == SEND) && (idx_q == '0);
      byte_last          = (state_q == SEND) && (idx_q == LAST_IDX);
      src_id             = src_q;
      ack                = ack_q;
   end

endmodule

// File: tb/tb_word_byte_sched.sv
module tb_word_byte_sched;

   logic         CLK_0 = 1'b0;
   logic         RST;
   logic [3:0]   req;
   logic [127:0] data_in;
   logic [3:0]   ack;
   logic [7:0]   byte_out;
   logic         byte_valid, byte_ready, byte_first, byte_last, busy;
   logic [1:0]   src_id;

   logic [1:0]   req1;
   logic [15:0]  data1;
   logic [1:0]   ack1;
   logic [7:0]   byte_out1;
   logic         valid1, ready1, first1, last1, busy1;
   logic [0:0]   src1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct packed {
      logic [7:0] b;
      logic       f;
      logic       l;
      logic [1:0] src;
   } exp_byte_t;

   typedef struct {
      int          rq;
      logic [31:0] w;
      int          stall_at;
      int          stall_len;
   } vec_t;

   exp_byte_t byte_q[$];
   int        grant_q[$];
   vec_t      vecs[5];

   always #5 CLK_0 = ~CLK_0;
   always @(posedge CLK_0) cyc <= cyc + 1;

   word_byte_sched #(
      .NREQ  (4),
      .BYTES (4)
   ) u_dut (
      .CLK_0      (CLK_0),
      .RST        (RST),
      .req        (req),
      .data_in    (data_in),
      .ack        (ack),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_first (byte_first),
      .byte_last  (byte_last),
      .src_id     (src_id),
      .busy       (busy)
   );

   word_byte_sched #(
      .NREQ  (2),
      .BYTES (1)
   ) u_dut1 (
      .CLK_0      (CLK_0),
      .RST        (RST),
      .req        (req1),
      .data_in    (data1),
      .ack        (ack1),
      .byte_out   (byte_out1),
      .byte_valid (valid1),
      .byte_ready (ready1),
      .byte_first (first1),
      .byte_last  (last1),
      .src_id     (src1),
      .busy       (busy1)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: bound expired (t=%0t)", nm, $time);
   endtask

   function automatic void push_word(input int rq, input logic [31:0] w);
      exp_byte_t e;
      for (int k = 0; k < 4; k++) begin
         e.b   = w[8*k +: 8];
         e.f   = (k == 0);
         e.l   = (k == 3);
         e.src = 2'(rq);
         byte_q.push_back(e);
      end
   endfunction

   // Scoreboard: grants and bytes are checked when the DUT produces them.
   always @(negedge CLK_0) begin
      if (!RST) begin
         if (ack != '0) begin
            if (grant_q.size() == 0) begin
               chk("ack_unexpected", 64'(ack), 64'(0));
            end else begin
               int g;
               g = grant_q.pop_front();
               chk("ack_onehot", 64'(ack), 64'(4'b0001 << g));
            end
         end
         if (byte_valid && byte_ready) begin
            if (byte_q.size() == 0) begin
               chk("byte_unexpected", 64'({byte_out, byte_first, byte_last, src_id}), 64'(0));
            end else begin
               exp_byte_t e;
               e = byte_q.pop_front();
               chk("byte_stream", 64'({byte_out, byte_first, byte_last, src_id}), 64'(e));
            end
         end
      end
   end

   task automatic wait_ack(output int idx, output int n);
      idx = -1;
      n   = 0;
      do begin
         @(posedge CLK_0);
         #1;
         n++;
      end while (ack == '0 && n < 40);
      if (ack == '0) fail("ack_timeout");
      for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((byte_q.size() != 0 || grant_q.size() != 0 || byte_valid) && n < 60) begin
         @(posedge CLK_0);
         #1;
         n++;
      end
      chk("drain", 64'(byte_q.size() + grant_q.size()), 64'(0));
   endtask

   // One word from a single requester, with an optional stall before byte stall_at.
   task automatic send_word(input int rq, input logic [31:0] w, input int stall_at,
                            input int stall_len);
      int   g, n, done, stalled;
      logic [7:0] sb;
      logic       sf, sl;
      @(posedge CLK_0);
      #1;
      data_in[rq*32 +: 32] = w;
      req[rq]              = 1'b1;
      grant_q.push_back(rq);
      push_word(rq, w);
      wait_ack(g, n);
      chk("grant_latency", 64'(n), 64'(1));
      req[rq] = 1'b0;
      done    = 0;
      stalled = 0;
      sb      = w[8*stall_at +: 8];
      sf      = (stall_at == 0);
      sl      = (stall_at == 3);
      for (int c = 0; c < 60 && done < 4; c++) begin
         if (c > 0) begin
            @(posedge CLK_0);
            #1;
         end
         if (done == stall_at && stalled < stall_len) begin
            byte_ready = 1'b0;
            stalled++;
            chk("stall_hold", 64'({byte_valid, byte_out, byte_first, byte_last, src_id}),
                64'({1'b1, sb, sf, sl, 2'(rq)}));
         end else begin
            byte_ready = 1'b1;
            done++;
         end
      end
      @(posedge CLK_0);
      #1;
      chk("idle_gap", 64'({byte_valid, busy}), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, n, prev;
      vecs[0] = '{0, 32'hA1B2C3D4, 0, 0};
      vecs[1] = '{1, 32'h01020304, 1, 5};
      vecs[2] = '{2, 32'hDEADBEEF, 0, 2};
      vecs[3] = '{3, 32'h00FF00FF, 3, 3};
      vecs[4] = '{1, 32'h12345678, 0, 0};

      RST        = 1'b1;
      req        = '0;
      data_in    = '0;
      byte_ready = 1'b1;
      req1       = '0;
      data1      = '0;
      ready1     = 1'b1;
      #1;
      chk("rst_ack", 64'(ack), 64'(0));
      chk("rst_outputs", 64'({byte_out, byte_valid, byte_first, byte_last, src_id, busy}),
          64'(0));
      repeat (2) @(negedge CLK_0);
      RST = 1'b0;

      // Single-requester words with assorted backpressure.
      for (int v = 0; v < 5; v++) begin
         send_word(vecs[v].rq, vecs[v].w, vecs[v].stall_at, vecs[v].stall_len);
      end

      // Pointer wrap: after a grant to 3, req 1001 goes to 0 first, then 3.
      send_word(3, 32'hC0FFEE03, 0, 0);
      @(posedge CLK_0);
      #1;
      data_in[31:0]   = 32'h0BADF00D;
      data_in[127:96] = 32'h76543210;
      req             = 4'b1001;
      grant_q.push_back(0);
      push_word(0, 32'h0BADF00D);
      grant_q.push_back(3);
      push_word(3, 32'h76543210);
      wait_ack(g, n);
      chk("wrap_first", 64'(g), 64'(0));
      req[0] = 1'b0;
      wait_ack(g, n);
      chk("wrap_second", 64'(g), 64'(3));
      req[3] = 1'b0;
      wait_drain();

      // Round robin with all requesters held from reset.
      @(negedge CLK_0);
      RST = 1'b1;
      byte_q.delete();
      grant_q.delete();
      for (int i = 0; i < 4; i++) data_in[i*32 +: 32] = 32'(32'h1111_1111 * (i + 1));
      req = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         grant_q.push_back(k % 4);
         push_word(k % 4, 32'(32'h1111_1111 * ((k % 4) + 1)));
      end
      @(negedge CLK_0);
      RST  = 1'b0;
      prev = 0;
      for (int k = 0; k < 6; k++) begin
         wait_ack(g, n);
         chk("rr_order", 64'(g), 64'(k % 4));
         if (k > 0) chk("rr_spacing", 64'(cyc - prev), 64'(5));
         prev = cyc;
         if (k == 5 || g < 0) begin
            req = '0;
         end else begin
            req[g] = 1'b0;
            @(posedge CLK_0);
            #1;
            req[g] = 1'b1;
         end
      end
      wait_drain();

      // Reset in the middle of a word.
      @(posedge CLK_0);
      #1;
      data_in[63:32] = 32'h55667788;
      req[1]         = 1'b1;
      grant_q.push_back(1);
      push_word(1, 32'h55667788);
      wait_ack(g, n);
      chk("mid_grant", 64'(g), 64'(1));
      req[1] = 1'b0;
      repeat (2) @(posedge CLK_0);
      #1;
      chk("mid_byte2", 64'({byte_valid, byte_out}), 64'({1'b1, 8'h66}));
      #2;
      RST = 1'b1;
      #1;
      chk("rst_async", 64'({byte_valid, busy, ack, byte_out, src_id}), 64'(0));
      byte_q.delete();
      grant_q.delete();
      @(negedge CLK_0);
      RST = 1'b0;
      send_word(2, 32'h9ABCDEF0, 0, 2);

      // Pointer back at NREQ-1 after reset: req 1001 grants 0 even though 2 was last.
      @(negedge CLK_0);
      RST = 1'b1;
      @(negedge CLK_0);
      RST = 1'b0;
      @(posedge CLK_0);
      #1;
      data_in[31:0]   = 32'hAABBCCDD;
      data_in[127:96] = 32'h10203040;
      req             = 4'b1001;
      grant_q.push_back(0);
      push_word(0, 32'hAABBCCDD);
      grant_q.push_back(3);
      push_word(3, 32'h10203040);
      wait_ack(g, n);
      chk("ptr_reset_grant", 64'(g), 64'(0));
      req[0] = 1'b0;
      wait_ack(g, n);
      chk("ptr_reset_next", 64'(g), 64'(3));
      req[3] = 1'b0;
      wait_drain();

      // Single-byte words: first and last together, one word every 2 cycles.
      @(posedge CLK_0);
      #1;
      data1 = 16'hA55A;
      req1  = 2'b11;
      @(posedge CLK_0);
      #1;
      chk("b1_ack0", 64'(ack1), 64'(2'b01));
      chk("b1_byte0", 64'({valid1, byte_out1, first1, last1, src1}),
          64'({1'b1, 8'h5A, 1'b1, 1'b1, 1'b0}));
      req1[0] = 1'b0;
      @(posedge CLK_0);
      #1;
      chk("b1_gap", 64'({valid1, ack1}), 64'(0));
      @(posedge CLK_0);
      #1;
      chk("b1_ack1", 64'(ack1), 64'(2'b10));
      chk("b1_byte1", 64'({valid1, byte_out1, first1, last1, src1}),
          64'({1'b1, 8'hA5, 1'b1, 1'b1, 1'b1}));
      req1 = '0;
      @(posedge CLK_0);
      #1;
      chk("b1_idle", 64'({valid1, busy1}), 64'(0));

      chk("sb_empty", 64'(byte_q.size() + grant_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
